// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe
//   Extends an IN_W-bit instruction field to OUT_W bits. The field is first
//   trimmed to an effective length L, then zero-extended, sign-extended or
//   placed in the high bits. The result is registered behind a valid/ready
//   stage with a one-entry skid buffer, so the unit runs at full throughput
//   while in_ready stays a plain flop.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   source word valid
//   in_ready   unit can accept a word this cycle (registered)
//   in_data    source field [IN_W-1:0]
//   in_mode    00 zero-ext, 01 sign-ext, 10 high-place, 11 reserved
//   in_len     effective field length; 0 or >IN_W selects IN_W
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   extended result [OUT_W-1:0]
//   out_err    result came from the reserved mode
//   err_sticky set by any accepted reserved-mode word, cleared only by reset
module ext_unit_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             err_sticky
);

    localparam int PAD_W = OUT_W - IN_W;

    // ---------------- combinational extension ----------------
    logic [LEN_W-1:0] w_len;
    logic [IN_W-1:0]  w_mask;
    logic [IN_W-1:0]  w_field;
    logic             w_sign;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext_data;
    logic             w_ext_err;

    always_comb begin
        w_len = in_len;
        if (in_len == '0 || in_len > LEN_W'(IN_W))
            w_len = LEN_W'(IN_W);

        w_mask = '0;
        w_sign = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            w_mask[i] = (LEN_W'(i) < w_len);
            // Top bit of the effective field supplies the sign.
            if (LEN_W'(i) == w_len - LEN_W'(1))
                w_sign = in_data[i];
        end
        w_field = in_data & w_mask;

        // Bits of the source field above L are replaced by the sign as well.
        w_sext = {{PAD_W{w_sign}}, w_field};
        for (int i = 0; i < IN_W; i++) begin
            if (!w_mask[i])
                w_sext[i] = w_sign;
        end

        w_ext_err = 1'b0;
        case (in_mode)
            2'b00:   w_ext_data = {{PAD_W{1'b0}}, w_field};
            2'b01:   w_ext_data = w_sext;
            2'b10:   w_ext_data = {w_field, {PAD_W{1'b0}}};
            default: begin
                w_ext_data = '0;
                w_ext_err  = 1'b1;
            end
        endcase
    end

    // ---------------- output register + skid ----------------
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_skid_err;
    logic             r_in_ready;
    logic             r_err_sticky;

    logic w_in_fire;
    logic w_out_free;

    assign w_in_fire  = in_valid & r_in_ready;
    // Output register can take a new word when empty or draining this cycle.
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_out_free) begin
                // in_ready is low whenever skid is full, so an input transfer
                // and a skid refill never coincide.
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_err    <= r_skid_err;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_in_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_ext_data;
                    r_out_err   <= w_ext_err;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_ext_data;
                r_skid_err   <= w_ext_err;
                r_in_ready   <= 1'b0;
            end

            if (w_in_fire && w_ext_err)
                r_err_sticky <= 1'b1;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;
    assign err_sticky = r_err_sticky;

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8-to-16 zero extender in the datapath.
- Extends an IN_W-bit immediate/operand field to OUT_W bits, with a runtime-selectable mode and effective field length.
- Registered valid/ready stage with a skid buffer: full throughput, registered in_ready.
- Sits between instruction-field decode and the ALU operand mux.

Parameters:
- IN_W, 8, maximum source field width (2 to OUT_W-1)
- OUT_W, 16, extended result width (> IN_W)
- LEN_W, 4, width of len port; must satisfy 2^LEN_W > IN_W

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  source word valid
- in_ready  output  1  unit can accept a word this cycle
- in_data  input  IN_W  source field
- in_mode  input  2  00 zero-ext, 01 sign-ext, 10 high-place, 11 reserved
- in_len  input  LEN_W  effective field length in bits; 0 or >IN_W means IN_W
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_W  extended result
- out_err  output  1  result came from reserved mode (travels with out_data)
- err_sticky  output  1  set on any accepted reserved-mode word; cleared only by reset

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - out_valid=0, out_data=0, out_err=0, err_sticky=0
  - skid buffer empty; in_ready=1 in the first cycle after reset deasserts
  - Any in-flight word is dropped.
- Effective length: L = in_len if 1 ≤ in_len ≤ IN_W, else L = IN_W. Bits in_data[IN_W-1:L] are ignored (masked to 0 before extension).
- Mode 00, zero-extend: out = {0s, in_data[L-1:0]}.
- Mode 01, sign-extend: bits [OUT_W-1:L] = in_data[L-1]; bits [L-1:0] = in_data[L-1:0].
- Mode 10, high-place: out = masked field << (OUT_W-IN_W); low OUT_W-IN_W bits are 0. L masking still applies.
- Mode 11, reserved: out_data=0, out_err=1, err_sticky set on acceptance.
- Computation is combinational on input; the result is captured into the output register.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
- Latency: a word accepted in cycle N is presented on out_valid/out_data in cycle N+1.
- Storage: main output register plus one skid register (2 entries).
  - in_ready is a flop, equal to !skid_full.
  - If the output register is full and not draining, an accepted word goes to skid; in_ready drops the next cycle.
  - When the output register drains and skid is full, skid moves to the output register; in_ready rises the next cycle.
  - Simultaneous input accept and output drain with skid empty: the new word goes straight to the output register; out_valid stays 1.
- Ordering is strictly FIFO; no word is dropped or duplicated under any in_valid/out_ready pattern.
- Stable-output rule: while out_valid=1 and out_ready=0, out_data and out_err hold unchanged.
- in_valid may drop without a handshake; once accepted, a word is committed.

Test Plan:
- Zero-extend, defaults, mode 00, len 8, data 8'h81 -> 16'h0081 one cycle after acceptance, out_err=0.
- Sign-extend: mode 01, len 8, data 8'h81 -> 16'hFF81. Len 4, data 8'h38 (upper nibble masked) -> 16'hFFF8. Len 4, data 8'h07 -> 16'h0007. Len 0, data 8'h7F -> 16'h007F.
- High-place and reserved: mode 10, data 8'hA5 -> 16'hA500. Then mode 11, data 8'hFF -> 16'h0000 with out_err=1; err_sticky=1 and stays 1 after following good words.
- Backpressure: stream 8'h01,8'h02,8'h03,8'h04 (mode 00) with out_ready=0 for 4 cycles.
  - Required: 8'h01 in output register, 8'h02 in skid, in_ready=0.
  - After out_ready=1: outputs 16'h0001,0002,0003,0004 in order, one per cycle; out_data stable while stalled.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles with incrementing data -> 16 consecutive out_valid cycles, in_ready never low.
- Reset mid-operation: assert reset with both entries full -> out_valid=0, out_data=0 and err_sticky=0 immediately (async); in_ready=1 after release; no stale word emerges.
